rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port (Reg_Write/Write_Register/Write_Data) among NUM_REQ requesters.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_write_arbiter_if.sv | 33 +++
 rtl/rr_picker.sv | 38 +++
 rtl/rf_write_arbiter.sv | 108 ++++++++++
 tb/tb_rf_write_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file write types and constants for the write-port arbiter.
package rf_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_SEL   = 5;

  typedef struct packed {
    logic [RF_SEL-1:0]   addr;
    logic [RF_WIDTH-1:0] data;
  } rf_wr_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side handshake bundle plus the registered register-file write port.
interface rf_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned SELECTOR = RF_SEL,
  parameter int unsigned NUM_REQ  = 4
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic                        stall_i;
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_lock_i;
  logic [NUM_REQ*SELECTOR-1:0] req_addr_i;
  logic [NUM_REQ*WIDTH-1:0]    req_data_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic                        Reg_Write_o;
  logic [SELECTOR-1:0]         Write_Register_o;
  logic [WIDTH-1:0]            Write_Data_o;
  logic [IdxW-1:0]             grant_id_o;
  logic                        locked_o;

  modport master (
    output stall_i, req_valid_i, req_lock_i, req_addr_i, req_data_i,
    input  req_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o, locked_o
  );

  modport slave (
    input  stall_i, req_valid_i, req_lock_i, req_addr_i, req_data_i,
    output req_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o, locked_o
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible request at or after ptr_i, wrapping.
module rr_picker #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  input  logic [NumReq-1:0] mask_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [NumReq-1:0] elig;
  int unsigned       pos;
  logic [IdxW-1:0]   k;

  assign elig = req_i & mask_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    k       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NumReq) pos = pos - NumReq;
      k = IdxW'(pos);
      if (!valid_o && elig[k]) begin
        valid_o    = 1'b1;
        idx_o      = k;
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with burst lock and reg-0 suppression.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned SELECTOR = RF_SEL,
  parameter int unsigned NUM_REQ  = 4
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                we_q, we_d;
  logic [SELECTOR-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [IdxW-1:0]     gid_q, gid_d;

  logic [NUM_REQ-1:0]  mask, grant;
  logic [IdxW-1:0]     pick_ptr, win;
  logic                win_vld, accept;
  logic [SELECTOR-1:0] win_addr;
  logic [WIDTH-1:0]    win_data;

  // While locked only the owner is eligible, so the picker starts its search there.
  assign mask     = (state_q == ARB_LOCKED) ? (NUM_REQ'(1) << owner_q) : '1;
  assign pick_ptr = (state_q == ARB_LOCKED) ? owner_q : ptr_q;

  rr_picker #(
    .NumReq (NUM_REQ)
  ) u_picker (
    .req_i   (bus.req_valid_i),
    .ptr_i   (pick_ptr),
    .mask_i  (mask),
    .grant_o (grant),
    .idx_o   (win),
    .valid_o (win_vld)
  );

  assign accept          = rst && !bus.stall_i && win_vld;
  assign bus.req_ready_o = accept ? grant : '0;
  assign win_addr        = bus.req_addr_i[32'(win)*SELECTOR +: SELECTOR];
  assign win_data        = bus.req_data_i[32'(win)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    if (accept) begin
      we_d    = (win_addr != '0);
      wreg_d  = win_addr;
      wdata_d = win_data;
      gid_d   = win;
    end
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          ptr_d = (win == IdxW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (bus.req_lock_i[win]) begin
            state_d = ARB_LOCKED;
            owner_d = win;
          end
        end
      end
      ARB_LOCKED: begin
        // Unstalled cycle without an owner beat abandons the burst.
        if (!bus.stall_i && (!accept || !bus.req_lock_i[owner_q])) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
    end
  end

  assign bus.Reg_Write_o      = we_q;
  assign bus.Write_Register_o = wreg_q;
  assign bus.Write_Data_o     = wdata_q;
  assign bus.grant_id_o       = gid_q;
  assign bus.locked_o         = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a per-beat behavioural arbitration model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = RF_WIDTH;
  localparam int unsigned S  = RF_SEL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.WIDTH(W), .SELECTOR(S), .NUM_REQ(N)) bus ();

  rf_write_arbiter #(
    .WIDTH    (W),
    .SELECTOR (S),
    .NUM_REQ  (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: pending beats held until accepted.
  bit     pend_v[N];
  bit     pend_l[N];
  rf_wr_t pend[N];
  bit     stall_b;

  // Reference model state.
  int             m_ptr;
  bit             m_locked;
  int             m_owner;
  bit             e_we;
  logic [S-1:0]   e_addr;
  logic [W-1:0]   e_data;
  int             e_gid;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_valid_i[k]           = pend_v[k];
      bus.req_lock_i[k]            = pend_l[k];
      bus.req_addr_i[k*S +: S]     = pend[k].addr;
      bus.req_data_i[k*W +: W]     = pend[k].data;
    end
    bus.stall_i = stall_b;
  endtask

  function automatic int ref_winner();
    if (!rst || stall_b) return -1;
    if (m_locked) return pend_v[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (pend_v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0;
    e_we = 0; e_addr = '0; e_data = '0; e_gid = 0;
  endtask

  // mode 0: random traffic, 1: all valid rotation, 2: all valid stalled
  task automatic gen(input int mode);
    for (int k = 0; k < N; k++) begin
      if (!pend_v[k]) begin
        if (mode != 0) begin
          pend_v[k] = 1; pend_l[k] = 0;
          pend[k].addr = S'(k + 1); pend[k].data = W'(32'hA0 + k);
        end else if ($urandom_range(1, 0) == 1) begin
          pend_v[k] = 1;
          pend_l[k] = ($urandom_range(2, 0) == 0);
          pend[k].addr = ($urandom_range(7, 0) == 0) ? '0 : S'($urandom);
          pend[k].data = W'($urandom);
        end
      end
    end
    stall_b = (mode == 2) ? 1'b1 : (mode == 0 && $urandom_range(7, 0) == 0);
    drive();
  endtask

  task automatic cycle(input int mode);
    int win;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    win = ref_winner();
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    check("ready", 64'(bus.req_ready_o), 64'(exp_ready));
    check("reg_write", 64'(bus.Reg_Write_o), 64'(e_we));
    check("write_register", 64'(bus.Write_Register_o), 64'(e_addr));
    check("write_data", 64'(bus.Write_Data_o), 64'(e_data));
    check("grant_id", 64'(bus.grant_id_o), 64'(e_gid));
    check("locked", 64'(bus.locked_o), 64'(m_locked));
    if (!rst) begin
      model_reset();
    end else if (win >= 0) begin
      e_we = (pend[win].addr != '0); e_addr = pend[win].addr;
      e_data = pend[win].data; e_gid = win;
      if (!m_locked) begin
        m_ptr = (win + 1) % N;
        if (pend_l[win]) begin m_locked = 1; m_owner = win; end
      end else if (!pend_l[win]) begin
        m_locked = 0;
      end
    end else begin
      e_we = 0;
      if (m_locked && !stall_b && !pend_v[m_owner]) m_locked = 0;
    end
    @(posedge clk);
    #1;
    if (win >= 0) pend_v[win] = 0;
    gen(mode);
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < N; k++) begin pend_v[k] = 0; pend_l[k] = 0; pend[k] = '0; end
    rst = 1'b0;
    gen(1);
    @(posedge clk);
    #1;
    // Reset held with every requester valid.
    cycle(1);
    cycle(1);
    rst = 1'b1;
    // Full rotation, then a stall mid-stream.
    for (int i = 0; i < 8; i++) cycle(1);
    cycle(2);
    cycle(2);
    cycle(2);
    for (int i = 0; i < 4; i++) cycle(1);
    // Lone register-0 write from requester 2.
    for (int k = 0; k < N; k++) pend_v[k] = 0;
    pend_v[2] = 1; pend_l[2] = 0; pend[2].addr = '0; pend[2].data = W'(32'hDEAD);
    stall_b = 0;
    drive();
    cycle(0);
    for (int k = 0; k < N; k++) pend_v[k] = 0;
    drive();
    cycle(0);
    // Random traffic with occasional resets, bursts and stalls.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(149, 0) != 0);
      cycle(0);
    end
    rst = 1'b1;
    cycle(0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
